// File: rtl/dict_pkg.sv
// rtl/dict_pkg.sv - op encodings and FSM state type for the key/value dictionary
package dict_pkg;

    localparam logic [1:0] OP_SET = 2'b00;
    localparam logic [1:0] OP_GET = 2'b01;
    localparam logic [1:0] OP_DEL = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/dict_key_cmp.sv
// rtl/dict_key_cmp.sv - full-key equality between a stored key and the request key
module dict_key_cmp #(
    parameter int KEY_WIDTH  = 8,
    parameter int KEY_LENGTH = 8
) (
    input  logic [KEY_WIDTH*KEY_LENGTH-1:0] stored_key,
    input  logic [KEY_WIDTH*KEY_LENGTH-1:0] req_key,
    output logic                            match
);

    logic [KEY_LENGTH-1:0] char_eq;

    for (genvar i = 0; i < KEY_LENGTH; i++) begin : g_char
        assign char_eq[i] = stored_key[i*KEY_WIDTH +: KEY_WIDTH] == req_key[i*KEY_WIDTH +: KEY_WIDTH];
    end

    assign match = &char_eq;

endmodule

// File: rtl/dict_kv.sv
// rtl/dict_kv.sv - linear-scan key/value dictionary with SET/GET/DEL/CLR requests
module dict_kv
    import dict_pkg::*;
#(
    parameter int ENTRIES     = 16,
    parameter int KEY_WIDTH   = 8,
    parameter int KEY_LENGTH  = 8,
    parameter int VALUE_WIDTH = 32
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic                                i_valid,
    output logic                                o_ready,
    input  logic [1:0]                          i_op,
    input  logic [KEY_WIDTH*KEY_LENGTH-1:0]     i_key,
    input  logic [VALUE_WIDTH-1:0]              i_value,
    output logic                                o_done,
    output logic                                o_found,
    output logic                                o_err,
    output logic [VALUE_WIDTH-1:0]              o_value,
    output logic [$clog2(ENTRIES+1)-1:0]        o_count
);

    localparam int KB = KEY_WIDTH * KEY_LENGTH;
    localparam int PW = $clog2(ENTRIES);
    localparam int CW = $clog2(ENTRIES + 1);

    state_t                 state_q;
    logic [1:0]             op_q;
    logic [KB-1:0]          key_q;
    logic [VALUE_WIDTH-1:0] value_q;
    logic [PW-1:0]          ptr_q;
    logic [PW-1:0]          free_q;
    logic                   free_found_q;
    logic [ENTRIES-1:0]     valid_q;
    logic [CW-1:0]          count_q;
    logic                   found_q;
    logic                   err_q;
    logic [VALUE_WIDTH-1:0] value_out_q;

    logic [KB-1:0]          key_mem [ENTRIES];
    logic [VALUE_WIDTH-1:0] val_mem [ENTRIES];

    logic          key_eq;
    logic          cur_valid;
    logic          hit;
    logic          last;
    logic          free_avail;
    logic [PW-1:0] free_idx;
    logic          scan_end;
    logic          wr_val_en;
    logic          wr_key_en;
    logic [PW-1:0] wr_idx;

    dict_key_cmp #(
        .KEY_WIDTH  (KEY_WIDTH),
        .KEY_LENGTH (KEY_LENGTH)
    ) u_key_cmp (
        .stored_key (key_mem[ptr_q]),
        .req_key    (key_q),
        .match      (key_eq)
    );

    // The entry under the pointer may itself be the first free slot on the final miss cycle.
    always_comb begin
        cur_valid  = valid_q[ptr_q];
        hit        = cur_valid && key_eq;
        last       = ptr_q == PW'(ENTRIES - 1);
        free_avail = free_found_q || !cur_valid;
        free_idx   = free_found_q ? free_q : ptr_q;
        scan_end   = (state_q == ST_SCAN) && (hit || last);
        wr_val_en  = 1'b0;
        wr_key_en  = 1'b0;
        wr_idx     = ptr_q;
        if (scan_end && op_q == OP_SET) begin
            if (hit) begin
                wr_val_en = 1'b1;
            end else if (free_avail) begin
                wr_val_en = 1'b1;
                wr_key_en = 1'b1;
                wr_idx    = free_idx;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_n && wr_val_en) val_mem[wr_idx] <= value_q;
        if (i_rst_n && wr_key_en) key_mem[wr_idx] <= key_q;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            op_q         <= OP_SET;
            ptr_q        <= '0;
            free_q       <= '0;
            free_found_q <= 1'b0;
            valid_q      <= '0;
            count_q      <= '0;
            found_q      <= 1'b0;
            err_q        <= 1'b0;
            value_out_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_valid) begin
                        op_q         <= i_op;
                        key_q        <= i_key;
                        value_q      <= i_value;
                        ptr_q        <= '0;
                        free_found_q <= 1'b0;
                        if (i_op == OP_CLR) begin
                            valid_q     <= '0;
                            count_q     <= '0;
                            found_q     <= 1'b0;
                            err_q       <= 1'b0;
                            value_out_q <= '0;
                            state_q     <= ST_DONE;
                        end else begin
                            state_q <= ST_SCAN;
                        end
                    end
                end
                ST_SCAN: begin
                    if (!free_found_q && !cur_valid) begin
                        free_found_q <= 1'b1;
                        free_q       <= ptr_q;
                    end
                    ptr_q <= ptr_q + PW'(1);
                    if (scan_end) begin
                        state_q     <= ST_DONE;
                        found_q     <= hit;
                        err_q       <= 1'b0;
                        value_out_q <= '0;
                        case (op_q)
                            OP_SET: begin
                                if (!hit) begin
                                    if (free_avail) begin
                                        valid_q[free_idx] <= 1'b1;
                                        count_q           <= count_q + CW'(1);
                                    end else begin
                                        err_q <= 1'b1;
                                    end
                                end
                            end
                            OP_GET: begin
                                if (hit) value_out_q <= val_mem[ptr_q];
                            end
                            OP_DEL: begin
                                if (hit) begin
                                    valid_q[ptr_q] <= 1'b0;
                                    count_q        <= count_q - CW'(1);
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_ready = state_q == ST_IDLE;
    assign o_done  = state_q == ST_DONE;
    assign o_found = found_q;
    assign o_err   = err_q;
    assign o_value = value_out_q;
    assign o_count = count_q;

endmodule

// File: tb/tb_dict_kv.sv
// tb/tb_dict_kv.sv - directed vector bench for dict_kv with a 4-entry table
module tb_dict_kv;
    import dict_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [1:0]  i_op;
    logic [63:0] i_key;
    logic [31:0] i_value;
    logic        o_done;
    logic        o_found;
    logic        o_err;
    logic [31:0] o_value;
    logic [2:0]  o_count;

    int n_pass  = 0;
    int n_total = 0;

    localparam logic [63:0] K_A = 64'h41;
    localparam logic [63:0] K_B = 64'h42;
    localparam logic [63:0] K_C = 64'h43;
    localparam logic [63:0] K_D = 64'h44;
    localparam logic [63:0] K_E = 64'h45;
    localparam logic [63:0] K_F = 64'h46;
    localparam logic [63:0] K_G = 64'h47;
    localparam logic [63:0] K_Q = 64'h51;
    localparam logic [63:0] K_Z = 64'h5A;

    dict_kv #(
        .ENTRIES     (4),
        .KEY_WIDTH   (8),
        .KEY_LENGTH  (8),
        .VALUE_WIDTH (32)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_op    (i_op),
        .i_key   (i_key),
        .i_value (i_value),
        .o_done  (o_done),
        .o_found (o_found),
        .o_err   (o_err),
        .o_value (o_value),
        .o_count (o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [63:0] key;
        logic [31:0] val;
        int          lat;
        logic        found;
        logic        err;
        logic [31:0] value;
        logic        chk_value;
        logic [2:0]  count;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    // lat counts rising edges after the accept edge until o_done is seen.
    task automatic run(input logic [1:0] op, input logic [63:0] key, input logic [31:0] val,
                       output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!o_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        i_valid = 1'b1;
        i_op    = op;
        i_key   = key;
        i_value = val;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        lat = 0;
        while (!o_done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int dones;
        int lat_seen;

        vecs[0]  = '{OP_SET, K_A, 32'h11, 4, 1'b0, 1'b0, 32'h0,  1'b0, 3'd1};
        vecs[1]  = '{OP_GET, K_A, 32'h0,  1, 1'b1, 1'b0, 32'h11, 1'b1, 3'd1};
        vecs[2]  = '{OP_GET, K_Z, 32'h0,  4, 1'b0, 1'b0, 32'h0,  1'b1, 3'd1};
        vecs[3]  = '{OP_SET, K_B, 32'h22, 4, 1'b0, 1'b0, 32'h0,  1'b0, 3'd2};
        vecs[4]  = '{OP_SET, K_C, 32'h33, 4, 1'b0, 1'b0, 32'h0,  1'b0, 3'd3};
        vecs[5]  = '{OP_SET, K_D, 32'h44, 4, 1'b0, 1'b0, 32'h0,  1'b0, 3'd4};
        vecs[6]  = '{OP_SET, K_E, 32'h55, 4, 1'b0, 1'b1, 32'h0,  1'b0, 3'd4};
        vecs[7]  = '{OP_GET, K_E, 32'h0,  4, 1'b0, 1'b0, 32'h0,  1'b1, 3'd4};
        vecs[8]  = '{OP_SET, K_B, 32'h99, 2, 1'b1, 1'b0, 32'h0,  1'b0, 3'd4};
        vecs[9]  = '{OP_GET, K_B, 32'h0,  2, 1'b1, 1'b0, 32'h99, 1'b1, 3'd4};
        vecs[10] = '{OP_DEL, K_B, 32'h0,  2, 1'b1, 1'b0, 32'h0,  1'b0, 3'd3};
        vecs[11] = '{OP_SET, K_F, 32'h66, 4, 1'b0, 1'b0, 32'h0,  1'b0, 3'd4};
        vecs[12] = '{OP_GET, K_F, 32'h0,  2, 1'b1, 1'b0, 32'h66, 1'b1, 3'd4};
        vecs[13] = '{OP_DEL, K_Q, 32'h0,  4, 1'b0, 1'b0, 32'h0,  1'b0, 3'd4};
        vecs[14] = '{OP_GET, K_D, 32'h0,  4, 1'b1, 1'b0, 32'h44, 1'b1, 3'd4};
        vecs[15] = '{OP_CLR, 64'h0, 32'h0, 0, 1'b0, 1'b0, 32'h0, 1'b0, 3'd0};
        vecs[16] = '{OP_GET, K_A, 32'h0,  4, 1'b0, 1'b0, 32'h0,  1'b1, 3'd0};
        vecs[17] = '{OP_GET, K_F, 32'h0,  4, 1'b0, 1'b0, 32'h0,  1'b1, 3'd0};

        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_op    = OP_SET;
        i_key   = '0;
        i_value = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ready", 64'(o_ready), 64'd1);
        chk("rst_done",  64'(o_done),  64'd0);
        chk("rst_found", 64'(o_found), 64'd0);
        chk("rst_err",   64'(o_err),   64'd0);
        chk("rst_value", 64'(o_value), 64'd0);
        chk("rst_count", 64'(o_count), 64'd0);

        for (int i = 0; i < 18; i++) begin
            run(vecs[i].op, vecs[i].key, vecs[i].val, lat);
            chk($sformatf("v%0d_lat", i),   64'(lat),     64'(vecs[i].lat));
            chk($sformatf("v%0d_found", i), 64'(o_found), 64'(vecs[i].found));
            chk($sformatf("v%0d_err", i),   64'(o_err),   64'(vecs[i].err));
            chk($sformatf("v%0d_count", i), 64'(o_count), 64'(vecs[i].count));
            if (vecs[i].chk_value)
                chk($sformatf("v%0d_value", i), 64'(o_value), 64'(vecs[i].value));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_done_pulse", i), 64'(o_done),  64'd0);
            chk($sformatf("v%0d_ready", i),      64'(o_ready), 64'd1);
        end

        // Request held with a different op during SCAN must not be taken.
        run(OP_SET, K_A, 32'h11, lat);
        chk("hold_setup_count", 64'(o_count), 64'd1);
        @(negedge clk);
        while (!o_ready) @(negedge clk);
        i_valid = 1'b1;
        i_op    = OP_GET;
        i_key   = K_A;
        @(posedge clk);
        #1;
        i_op     = OP_DEL;
        dones    = 0;
        lat_seen = 0;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            #1;
            if (o_done) begin
                dones++;
                if (dones == 1) lat_seen = c;
                i_valid = 1'b0;
            end
        end
        i_valid = 1'b0;
        chk("hold_dones",  64'(dones),    64'd1);
        chk("hold_lat",    64'(lat_seen), 64'd1);
        chk("hold_found",  64'(o_found),  64'd1);
        chk("hold_value",  64'(o_value),  64'h11);
        chk("hold_count",  64'(o_count),  64'd1);
        run(OP_GET, K_A, 32'h0, lat);
        chk("hold_get_found", 64'(o_found), 64'd1);

        // Reset during the SCAN of a SET aborts it without a completion.
        @(negedge clk);
        while (!o_ready) @(negedge clk);
        i_valid = 1'b1;
        i_op    = OP_SET;
        i_key   = K_G;
        i_value = 32'h77;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rscan_busy", 64'(o_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rscan_done",  64'(o_done),  64'd0);
        chk("rscan_ready", 64'(o_ready), 64'd1);
        chk("rscan_count", 64'(o_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (o_done) dones++;
        end
        chk("rscan_no_done", 64'(dones), 64'd0);
        run(OP_GET, K_G, 32'h0, lat);
        chk("rscan_get_lat",   64'(lat),     64'd4);
        chk("rscan_get_found", 64'(o_found), 64'd0);
        chk("rscan_get_count", 64'(o_count), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
